// File: rtl/clm_serial_multiplier.sv
// Digit-serial carry-less multiplier over redundant GF(2^8): W multiplier bits per cycle
// into a P-bit accumulator, then a single-cycle systematic reduction that mixes in refresh r.
module clm_serial_multiplier #(
  parameter int D = 4,
  parameter int W = 1,
  parameter logic [0:6+2*D][0:7] B_EXT = '0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [7+D:0]                  p1,
  input  logic [7+D:0]                  p2,
  input  logic [(D > 0 ? D : 1)-1:0]    r,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [7+D:0]                  out
);

  localparam int N  = 8 + D;
  localparam int P  = 2 * N - 1;
  localparam int C  = (N + W - 1) / W;
  localparam int CW = $clog2(C + 1);
  localparam int IW = $clog2(N);
  localparam int RW = (D > 0) ? D : 1;
  localparam int VW = N - 1 + D;

  // Handshake: a transfer happens on a rising edge where valid && ready; the producer
  // holds p1/p2/r until accepted, and out/out_valid stay stable until out_ready.
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_RED, S_OUT} state_t;

  state_t          state_q, state_d;
  logic [N-1:0]    p1_q, p1_d;
  logic [N-1:0]    p2_q, p2_d;
  logic [RW-1:0]   r_q, r_d;
  logic [P-1:0]    acc_q, acc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [N-1:0]    out_q, out_d;
  logic [VW-1:0]   v;
  logic            par;
  int              idx;
  logic [IW-1:0]   bit_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      p1_q    <= '0;
      p2_q    <= '0;
      r_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      p1_q    <= p1_d;
      p2_q    <= p2_d;
      r_q     <= r_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (in_valid) state_d = S_MUL;
      S_MUL:   if (cnt_q == CW'(C - 1)) state_d = S_RED;
      S_RED:   state_d = S_OUT;
      S_OUT:   if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == S_IDLE);
    out_valid = (state_q == S_OUT);
    out       = out_q;
  end

  always_comb begin
    p1_d  = p1_q;
    p2_d  = p2_q;
    r_d   = r_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    out_d = out_q;
    v     = '0;
    par   = 1'b0;
    idx   = 0;
    bit_i = '0;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          p1_d  = p1;
          p2_d  = p2;
          r_d   = r;
          acc_d = '0;
          cnt_d = '0;
        end
      end
      S_MUL: begin
        // Multiplier bits past N in a partial last digit contribute nothing.
        for (int j = 0; j < W; j++) begin
          idx   = int'(cnt_q) * W + j;
          bit_i = IW'(idx);
          if (idx < N && p2_q[bit_i]) acc_d = acc_d ^ (P'(p1_q) << bit_i);
        end
        cnt_d = cnt_q + CW'(1);
      end
      S_RED: begin
        for (int m = 0; m < D; m++) v[m] = r_q[m];
        for (int k = 0; k < N - 1; k++) v[D + k] = acc_q[N + k];
        for (int b = 0; b < 8; b++) begin
          par = 1'b0;
          for (int k = 0; k < VW; k++) par = par ^ (v[k] & B_EXT[k][b]);
          out_d[b] = acc_q[b] ^ par;
        end
        for (int m = 0; m < D; m++) out_d[8 + m] = acc_q[8 + m] ^ r_q[m];
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_clm_serial_multiplier.sv
// Bench for clm_serial_multiplier: three configurations (D=0/W=1, D=0/W=3, D=4/W=4) driven
// with directed vectors and random operands, checked against a GF-arithmetic reference.
module tb_clm_serial_multiplier;

  // Row b-bit of each constant is the coefficient of x^b.
  localparam logic [0:6][7:0]  AES_ROWS = {8'h1B, 8'h36, 8'h6C, 8'hD8, 8'hAB, 8'h4D, 8'h9A};
  localparam logic [0:14][7:0] B4_ROWS  = {8'hA5, 8'h3C, 8'h0F, 8'hC3,
                                           8'h1B, 8'h36, 8'h6C, 8'hD8, 8'hAB, 8'h4D, 8'h9A,
                                           8'h2F, 8'h5E, 8'hBC, 8'h63};

  function automatic logic [0:6][0:7] to_bext0(input logic [0:6][7:0] x);
    logic [0:6][0:7] t;
    for (int k = 0; k < 7; k++) for (int b = 0; b < 8; b++) t[k][b] = x[k][b];
    return t;
  endfunction

  function automatic logic [0:14][0:7] to_bext4(input logic [0:14][7:0] x);
    logic [0:14][0:7] t;
    for (int k = 0; k < 15; k++) for (int b = 0; b < 8; b++) t[k][b] = x[k][b];
    return t;
  endfunction

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        in_valid_s  [3];
  logic        in_ready_s  [3];
  logic        out_valid_s [3];
  logic        out_ready_s [3];
  logic [11:0] p1_s        [3];
  logic [11:0] p2_s        [3];
  logic [3:0]  r_s         [3];
  logic [11:0] out_s       [3];
  logic [11:0] last_out    [3];
  logic [7:0]  out0, out1;
  logic [11:0] out2;

  assign out_s[0] = {4'h0, out0};
  assign out_s[1] = {4'h0, out1};
  assign out_s[2] = out2;

  clm_serial_multiplier #(.D(0), .W(1), .B_EXT(to_bext0(AES_ROWS))) u_dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid_s[0]), .in_ready(in_ready_s[0]),
    .p1(p1_s[0][7:0]), .p2(p2_s[0][7:0]), .r(r_s[0][0]),
    .out_valid(out_valid_s[0]), .out_ready(out_ready_s[0]), .out(out0));

  clm_serial_multiplier #(.D(0), .W(3), .B_EXT(to_bext0(AES_ROWS))) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid_s[1]), .in_ready(in_ready_s[1]),
    .p1(p1_s[1][7:0]), .p2(p2_s[1][7:0]), .r(r_s[1][0]),
    .out_valid(out_valid_s[1]), .out_ready(out_ready_s[1]), .out(out1));

  clm_serial_multiplier #(.D(4), .W(4), .B_EXT(to_bext4(B4_ROWS))) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid_s[2]), .in_ready(in_ready_s[2]),
    .p1(p1_s[2]), .p2(p2_s[2]), .r(r_s[2]),
    .out_valid(out_valid_s[2]), .out_ready(out_ready_s[2]), .out(out2));

  // scoreboard
  logic [11:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // reference model
  function automatic logic [7:0] gf_mul_aes(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] x   = a;
    logic [7:0] res = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) res = res ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
    end
    return res;
  endfunction

  function automatic logic [22:0] clmul12(input logic [11:0] a, input logic [11:0] b);
    logic [22:0] acc = '0;
    for (int i = 0; i < 12; i++) if (b[i]) acc = acc ^ (23'(a) << i);
    return acc;
  endfunction

  function automatic logic [11:0] model(input int u, input logic [11:0] a, input logic [11:0] b,
                                        input logic [3:0] rv);
    logic [22:0] acc;
    logic [14:0] v;
    logic [11:0] res;
    logic        p;
    if (u < 2) return {4'h0, gf_mul_aes(a[7:0], b[7:0])};
    acc = clmul12(a, b);
    v   = {acc[22:12], rv};
    res[11:8] = acc[11:8] ^ rv;
    for (int bb = 0; bb < 8; bb++) begin
      p = 1'b0;
      for (int k = 0; k < 15; k++) p = p ^ (v[k] & B4_ROWS[k][bb]);
      res[bb] = acc[bb] ^ p;
    end
    return res;
  endfunction

  // Effect of changing only r: the r-rows on the low byte, r itself on the top bits.
  function automatic logic [11:0] r_delta(input logic [3:0] rd);
    logic [11:0] d;
    d[11:8] = rd;
    for (int bb = 0; bb < 8; bb++) begin
      d[bb] = 1'b0;
      for (int k = 0; k < 4; k++) d[bb] = d[bb] ^ (rd[k] & B4_ROWS[k][bb]);
    end
    return d;
  endfunction

  function automatic int lat_of(input int u);
    return (u == 0) ? 9 : 4;
  endfunction

  // driver: one full operation with optional output stall
  task automatic run_op(input int u, input logic [11:0] a, input logic [11:0] b,
                        input logic [3:0] rv, input int stall);
    int          lat;
    logic [11:0] held;
    logic [11:0] exp_v;
    @(negedge clk);
    p1_s[u] = a;
    p2_s[u] = b;
    r_s[u]  = rv;
    in_valid_s[u] = 1'b1;
    lat = 0;
    while (!in_ready_s[u] && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    chk("in_ready_idle", 32'(in_ready_s[u]), 32'd1);
    @(posedge clk);
    #1;
    in_valid_s[u] = 1'b0;
    exp_q.push_back(model(u, a, b, rv));
    lat = 0;
    while (!out_valid_s[u] && lat < 100) begin
      chk("in_ready_busy", 32'(in_ready_s[u]), 32'd0);
      @(posedge clk);
      #1;
      lat++;
    end
    chk("latency", 32'(lat), 32'(lat_of(u)));
    exp_v = exp_q.pop_front();
    chk("result", 32'(out_s[u]), 32'(exp_v));
    held = out_s[u];
    last_out[u] = held;
    for (int s = 0; s < stall; s++) begin
      @(posedge clk);
      #1;
      chk("hold_valid", 32'(out_valid_s[u]), 32'd1);
      chk("hold_out", 32'(out_s[u]), 32'(held));
      chk("hold_in_ready", 32'(in_ready_s[u]), 32'd0);
    end
    @(negedge clk);
    out_ready_s[u] = 1'b1;
    @(posedge clk);
    #1;
    out_ready_s[u] = 1'b0;
    chk("post_out_valid", 32'(out_valid_s[u]), 32'd0);
    chk("post_in_ready", 32'(in_ready_s[u]), 32'd1);
  endtask

  logic [11:0] o1, o2, ra, rb;

  initial begin
    for (int u = 0; u < 3; u++) begin
      in_valid_s[u]  = 1'b0;
      out_ready_s[u] = 1'b0;
      p1_s[u]        = '0;
      p2_s[u]        = '0;
      r_s[u]         = '0;
      last_out[u]    = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int u = 0; u < 3; u++) begin
      chk("reset_in_ready", 32'(in_ready_s[u]), 32'd1);
      chk("reset_out_valid", 32'(out_valid_s[u]), 32'd0);
      chk("reset_out", 32'(out_s[u]), 32'd0);
    end

    // AES vectors, full and partial-digit configurations
    run_op(0, 12'h057, 12'h083, 4'h0, 0);
    chk("aes_57x83", 32'(last_out[0]), 32'h0C1);
    run_op(1, 12'h057, 12'h013, 4'h0, 0);
    chk("aes_57x13", 32'(last_out[1]), 32'h0FE);
    run_op(1, 12'h000, 12'h0B7, 4'h0, 1);
    chk("zero_p1", 32'(last_out[1]), 32'h000);
    run_op(1, 12'h0E4, 12'h000, 4'h0, 2);
    chk("zero_p2", 32'(last_out[1]), 32'h000);

    // long backpressure
    run_op(0, 12'h057, 12'h083, 4'h0, 20);

    // reset during the second multiply cycle
    @(negedge clk);
    p1_s[0] = 12'h0A3;
    p2_s[0] = 12'h0FF;
    in_valid_s[0] = 1'b1;
    @(posedge clk);
    #1;
    in_valid_s[0] = 1'b0;
    chk("mid_busy", 32'(in_ready_s[0]), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("mid_rst_out_valid", 32'(out_valid_s[0]), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready_s[0]), 32'd1);
    chk("mid_rst_out", 32'(out_s[0]), 32'd0);
    run_op(0, 12'h057, 12'h083, 4'h0, 0);
    chk("after_rst_57x83", 32'(last_out[0]), 32'h0C1);

    // refresh: only r changes between the two operations
    for (int t = 0; t < 4; t++) begin
      o1 = 12'($urandom_range(0, 4095));
      o2 = 12'($urandom_range(0, 4095));
      ra = 12'($urandom_range(0, 15));
      rb = 12'($urandom_range(0, 15));
      run_op(2, o1, o2, ra[3:0], 0);
      o1 = last_out[2];
      run_op(2, o1 ^ o1 ^ p1_s[2], p2_s[2], rb[3:0], 1);
      chk("refresh_delta", 32'(o1 ^ last_out[2]), 32'(r_delta(ra[3:0] ^ rb[3:0])));
    end

    // random operands with random output stalls
    for (int i = 0; i < 1500; i++)
      run_op(2, 12'($urandom_range(0, 4095)), 12'($urandom_range(0, 4095)),
             4'($urandom_range(0, 15)), $urandom_range(0, 3));
    for (int i = 0; i < 150; i++)
      run_op(0, 12'($urandom_range(0, 255)), 12'($urandom_range(0, 255)), 4'h0,
             $urandom_range(0, 3));
    for (int i = 0; i < 300; i++)
      run_op(1, 12'($urandom_range(0, 255)), 12'($urandom_range(0, 255)), 4'h0,
             $urandom_range(0, 3));

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
